cr16_datapath: RTL and testbench
================================

# cr16_datapath

Execution datapath driven by the sequencer's per-cycle control word (`alu_op`, `muxes`, `regs_en`, `imm`). It holds the sixteen 16-bit general registers and the processor status flags, and executes one ALU operation per clock. Results are written back at the clock edge. It sits directly downstream of the control FSMs and feeds the display/debug logic through `wb_data` and `flags`.

## Interface
- No parameters; width fixed at 16 bits, 16 registers.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alu_op`  in  8  `{opcode[7:4], ext[3:0]}`; `opcode` 0000 = register-register; any other opcode = immediate form.
- `muxes`  in  8  `[7:4]` selects operand A register, `[3:0]` selects operand B register.
- `regs_en`  in  16  one-hot (or multi-hot) write enable; bit n writes Rn.
- `imm`  in  16  immediate operand B for immediate-form ops.
- `alu_out`  out  16  combinational result of the current control word.
- `wb_data`  out  16  registered; last value written to any register.
- `flags`  out  5  registered `{N, Z, L, F, C}`.
- `illegal`  out  1  registered; high for one cycle after an unsupported `alu_op`.

## Operation
- A = R[`muxes[7:4]`]. B = R[`muxes[3:0]`] for R-form, `imm` for I-form. Reads are combinational from current register contents.
- R-form (opcode 0000), by `ext`: 0101 ADD A+B; 1001 SUB A−B; 0001 AND; 0010 OR; 0011 XOR; 1101 MOV (B); 1011 CMP (flags only, `alu_out`=A−B).
- I-form, by opcode with `ext` ignored: 0101 ADDI; 1001 SUBI; 0001 ANDI; 0010 ORI; 0011 XORI; 1101 MOVI; 1011 CMPI; 1111 LUI (`imm[7:0]`<<8).
- Arithmetic is modulo 2^16.
- ADD/ADDI: C = carry out of bit 15; F = signed overflow.
- SUB/SUBI/CMP/CMPI: C = unsigned borrow (A<B); F = signed overflow.
- CMP/CMPI also set Z = (A==B), L = A<B unsigned, N = A<B signed.
- ADD/SUB family leave Z, L, N unchanged. Logic, MOV and LUI leave all flags unchanged.
- Write-back: every Rn with `regs_en[n]`=1 gets `alu_out` at the edge. Multiple set bits write the same value to all selected registers.
- `wb_data` updates to `alu_out` whenever `regs_en`≠0; it holds otherwise.
- Unsupported or unknown (X) `alu_op` with `regs_en`≠0: no register write, no flag change, `wb_data` holds, `illegal` pulses.
- Unsupported `alu_op` with `regs_en`=0: ignored silently, no `illegal` pulse.
- CMP writes registers if `regs_en`≠0; the control word is responsible for setting it to 0.
- Writing and reading the same register in one cycle: the read returns the old value; the new value is visible next cycle. No forwarding.

## Timing
- Reset asserted, asynchronously: all R0–R15 = 0, `flags` = 0, `wb_data` = 0, `illegal` = 0.
- Reset mid-sequence discards any in-flight write; the first write after release happens at the first rising edge with `reset`=1.
- `alu_out` is valid in the same cycle as the control word.
- Register, flag and `wb_data` updates have 1-cycle latency.
- Back-to-back dependent ops (write Rn in cycle k, read Rn in cycle k+1) are supported at full rate.

## Configuration
- `CR16_DATAPATH_SHIFT_EN` defined:
  - `alu_op` 8'h84 is LSH: A shifted by signed `B[4:0]`, positive = left, negative = logical right; magnitude ≥16 gives 0.
  - `alu_op` 8'h80 is LSHI: same shift, by `imm[4:0]`.
  - Flags are unchanged by both.
- Macro undefined: opcode 1000 is unsupported and is treated as illegal per Operation.

## Test plan
- Fibonacci: apply the sequencer's 16-word sequence (ADDI R1,1, then ADD Rn←Rn−2+Rn−1) -> `wb_data` reads 1,1,2,3,5,…,610; R15=610 and holds.
- Borrow/overflow: R1=0x0001, R2=0x0002, SUB into R3 -> R3=0xFFFF, C=1, F=0. R1=0x7FFF, ADDI imm=1 -> 0x8000, F=1, C=0.
- CMP: R4=0xFFFF, R5=0x0001, CMP A=R4 B=R5, `regs_en`=0 -> Z=0, L=0, N=1; no register changes; `wb_data` holds.
- Multi-write and illegal op:
  - MOVI 0x1234 with `regs_en`=0x0006 -> R1=R2=0x1234.
  - Then `alu_op`=8'h70 with `regs_en`=0x0001 -> R0 unchanged, `illegal`=1 for exactly one cycle.
- Reset mid-run: drop `reset` between edges during the Fibonacci sequence -> all outputs 0 immediately; the sequence restarts cleanly after release.
- Shift (macro defined): R1=0x00F0; LSHI imm=0x0004 -> 0x0F00; imm=0x001C (−4) -> 0x000F. With the macro undefined, the same words -> `illegal` pulses and no write.

Source files
------------

// File: rtl/cr16_datapath.sv
// rtl/cr16_datapath.sv - CR16 execution datapath: 16x16 register file, ALU, status flags (optional shifter under CR16_DATAPATH_SHIFT_EN)
module cr16_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  alu_op,
    input  logic [7:0]  muxes,
    input  logic [15:0] regs_en,
    input  logic [15:0] imm,
    output logic [15:0] alu_out,
    output logic [15:0] wb_data,
    output logic [4:0]  flags,
    output logic        illegal
);

    // Internal operation classes after decoding R-form ext / I-form opcode.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_LUI = 4'd7;
    localparam logic [3:0] OP_SHF = 4'd8;
    localparam logic [3:0] OP_BAD = 4'd9;

    // Flag bit positions within {N, Z, L, F, C}.
    localparam int FLG_C = 0;
    localparam int FLG_F = 1;
    localparam int FLG_L = 2;
    localparam int FLG_Z = 3;
    localparam int FLG_N = 4;

    logic [15:0] rf [16];

    logic [3:0]  op_cls;
    logic        use_imm;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [16:0] sum;
    logic [16:0] diff;
    logic        add_ovf;
    logic        sub_ovf;
    logic        signed_lt;
    logic [15:0] sh_res;
    logic [4:0]  flags_nxt;
    logic        legal;
    logic        wr_any;

    // Decode the control word; any pattern not listed (including X bits in
    // the opcode) falls through to OP_BAD.
    always_comb begin
        op_cls  = OP_BAD;
        use_imm = 1'b0;
        casez (alu_op)
            8'b0000_0101: op_cls = OP_ADD;
            8'b0000_1001: op_cls = OP_SUB;
            8'b0000_0001: op_cls = OP_AND;
            8'b0000_0010: op_cls = OP_OR;
            8'b0000_0011: op_cls = OP_XOR;
            8'b0000_1101: op_cls = OP_MOV;
            8'b0000_1011: op_cls = OP_CMP;
            8'b0101_????: begin op_cls = OP_ADD; use_imm = 1'b1; end
            8'b1001_????: begin op_cls = OP_SUB; use_imm = 1'b1; end
            8'b0001_????: begin op_cls = OP_AND; use_imm = 1'b1; end
            8'b0010_????: begin op_cls = OP_OR;  use_imm = 1'b1; end
            8'b0011_????: begin op_cls = OP_XOR; use_imm = 1'b1; end
            8'b1101_????: begin op_cls = OP_MOV; use_imm = 1'b1; end
            8'b1011_????: begin op_cls = OP_CMP; use_imm = 1'b1; end
            8'b1111_????: begin op_cls = OP_LUI; use_imm = 1'b1; end
`ifdef CR16_DATAPATH_SHIFT_EN
            8'h84:        op_cls = OP_SHF;
            8'h80:        begin op_cls = OP_SHF; use_imm = 1'b1; end
`endif
            default:      op_cls = OP_BAD;
        endcase
    end

    // Operand fetch straight from the register array; a write in this
    // cycle is only visible after the edge (no forwarding).
    always_comb begin
        op_a = rf[muxes[7:4]];
        op_b = use_imm ? imm : rf[muxes[3:0]];
    end

    // Adder/subtractor with carry, borrow and signed-overflow detection.
    always_comb begin
        sum       = {1'b0, op_a} + {1'b0, op_b};
        diff      = {1'b0, op_a} - {1'b0, op_b};
        add_ovf   = (op_a[15] == op_b[15]) && (sum[15] != op_a[15]);
        sub_ovf   = (op_a[15] != op_b[15]) && (diff[15] != op_a[15]);
        signed_lt = diff[15] ^ sub_ovf;
    end

`ifdef CR16_DATAPATH_SHIFT_EN
    logic [4:0] sh_amt;
    logic [4:0] sh_mag;

    // Logical shift by a signed 5-bit count: positive left, negative right;
    // the only reachable magnitude >= 16 is -16, which clears the result.
    always_comb begin
        sh_amt = op_b[4:0];
        sh_mag = 5'd0 - sh_amt;
        if (!sh_amt[4]) begin
            sh_res = op_a << sh_amt[3:0];
        end else if (sh_mag[4]) begin
            sh_res = '0;
        end else begin
            sh_res = op_a >> sh_mag[3:0];
        end
    end
`else
    // Shifter not built: opcode 1000 decodes as illegal, result never used.
    always_comb begin
        sh_res = '0;
    end
`endif

    // Result mux and next-flag computation for the current control word.
    always_comb begin
        alu_out   = '0;
        flags_nxt = flags;
        case (op_cls)
            OP_ADD: begin
                alu_out          = sum[15:0];
                flags_nxt[FLG_C] = sum[16];
                flags_nxt[FLG_F] = add_ovf;
            end
            OP_SUB: begin
                alu_out          = diff[15:0];
                flags_nxt[FLG_C] = diff[16];
                flags_nxt[FLG_F] = sub_ovf;
            end
            OP_CMP: begin
                alu_out          = diff[15:0];
                flags_nxt[FLG_C] = diff[16];
                flags_nxt[FLG_F] = sub_ovf;
                flags_nxt[FLG_L] = diff[16];
                flags_nxt[FLG_Z] = (op_a == op_b);
                flags_nxt[FLG_N] = signed_lt;
            end
            OP_AND:  alu_out = op_a & op_b;
            OP_OR:   alu_out = op_a | op_b;
            OP_XOR:  alu_out = op_a ^ op_b;
            OP_MOV:  alu_out = op_b;
            OP_LUI:  alu_out = {imm[7:0], 8'h00};
            OP_SHF:  alu_out = sh_res;
            default: alu_out = '0;
        endcase
    end

    // Qualifiers shared by the write-back and status registers.
    always_comb begin
        legal  = (op_cls != OP_BAD);
        wr_any = |regs_en;
    end

    // Register file write-back: every enabled register takes the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                rf[i] <= '0;
            end
        end else if (legal) begin
            for (int i = 0; i < 16; i++) begin
                if (regs_en[i]) begin
                    rf[i] <= alu_out;
                end
            end
        end
    end

    // Status: flags, last written value and the one-cycle illegal pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags   <= '0;
            wb_data <= '0;
            illegal <= 1'b0;
        end else begin
            if (legal) begin
                flags <= flags_nxt;
            end
            if (legal && wr_any) begin
                wb_data <= alu_out;
            end
            illegal <= !legal && wr_any;
        end
    end

endmodule

// File: tb/tb_cr16_datapath.sv
// tb/tb_cr16_datapath.sv - scoreboard testbench for cr16_datapath
module tb_cr16_datapath;

    logic        clk;
    logic        reset;
    logic [7:0]  alu_op;
    logic [7:0]  muxes;
    logic [15:0] regs_en;
    logic [15:0] imm;
    logic [15:0] alu_out;
    logic [15:0] wb_data;
    logic [4:0]  flags;
    logic        illegal;

    cr16_datapath dut (
        .clk     (clk),
        .reset   (reset),
        .alu_op  (alu_op),
        .muxes   (muxes),
        .regs_en (regs_en),
        .imm     (imm),
        .alu_out (alu_out),
        .wb_data (wb_data),
        .flags   (flags),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ea;
        logic        chk_a;
        logic [15:0] wb;
        logic [4:0]  fl;
        logic        ill;
        int          id;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          passes = 0;
    int          n_issued = 0;
    logic [15:0] cur_wb = '0;
    logic [4:0]  cur_flags = '0;
    logic [15:0] fib [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    endtask

    // Drive one control word and push what the DUT must show for it.
    task automatic issue(input logic [7:0] op, input logic [7:0] mx, input logic [15:0] en,
                         input logic [15:0] im, input logic [15:0] ea, input logic [4:0] ef,
                         input logic bad);
        exp_t e;
        @(posedge clk);
        #2;
        alu_op  = op;
        muxes   = mx;
        regs_en = en;
        imm     = im;
        if (!bad) begin
            cur_flags = ef;
            if (en != 16'h0) cur_wb = ea;
        end
        e.ea    = ea;
        e.chk_a = !bad;
        e.wb    = cur_wb;
        e.fl    = cur_flags;
        e.ill   = bad && (en != 16'h0);
        e.id    = n_issued;
        n_issued++;
        q.push_back(e);
    endtask

    task automatic nop();
        issue(8'h70, 8'h00, 16'h0000, 16'h0000, 16'h0000, cur_flags, 1'b1);
    endtask

    task automatic rd(input logic [3:0] r, input logic [15:0] v);
        issue(8'h0D, {4'h0, r}, 16'h0000, 16'h0000, v, cur_flags, 1'b0);
    endtask

    task automatic fib_run(input int last);
        issue(8'h50, 8'h00, 16'h0002, 16'h0001, fib[1], 5'b00000, 1'b0);
        for (int n = 2; n <= last; n++) begin
            issue(8'h05, {4'(n - 2), 4'(n - 1)}, 16'(1) << n, 16'h0000, fib[n], 5'b00000, 1'b0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        #2;
        chk("drain_queue_empty", q.size(), 0);
    endtask

    // Monitor: combinational result mid-cycle, registered state after the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                mon_e = q[0];
                if (mon_e.chk_a) chk($sformatf("alu_out#%0d", mon_e.id), alu_out, mon_e.ea);
                @(posedge clk);
                #1;
                void'(q.pop_front());
                chk($sformatf("wb_data#%0d", mon_e.id), wb_data, mon_e.wb);
                chk($sformatf("flags#%0d", mon_e.id), flags, mon_e.fl);
                chk($sformatf("illegal#%0d", mon_e.id), illegal, mon_e.ill);
            end
        end
    end

    initial begin
        fib = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21,
                16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610};
        reset   = 1'b0;
        alu_op  = 8'h70;
        muxes   = 8'h00;
        regs_en = 16'h0000;
        imm     = 16'h0000;
        #12;
        chk("reset_wb", wb_data, 16'h0);
        chk("reset_flags", flags, 5'h0);
        chk("reset_illegal", illegal, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Partial Fibonacci, then a reset that lands between edges.
        fib_run(8);
        nop();
        drain();
        #1;
        alu_op  = 8'h05;
        muxes   = 8'h78;
        regs_en = 16'h0200;
        #1;
        reset = 1'b0;
        #1;
        chk("midreset_wb", wb_data, 16'h0);
        chk("midreset_flags", flags, 5'h0);
        chk("midreset_alu", alu_out, 16'h0);
        @(posedge clk);
        #1;
        chk("midreset_held_wb", wb_data, 16'h0);
        regs_en = 16'h0000;
        alu_op  = 8'h70;
        @(negedge clk);
        reset     = 1'b1;
        cur_wb    = '0;
        cur_flags = '0;
        rd(4'd9, 16'h0000);
        rd(4'd8, 16'h0000);

        // Full Fibonacci after restart; R15 holds 610.
        fib_run(15);
        nop();
        nop();
        rd(4'd15, 16'd610);
        rd(4'd14, 16'd377);

        // Borrow and overflow.
        issue(8'hD0, 8'h00, 16'h0002, 16'h0001, 16'h0001, cur_flags, 1'b0);
        issue(8'hD0, 8'h00, 16'h0004, 16'h0002, 16'h0002, cur_flags, 1'b0);
        issue(8'h09, 8'h12, 16'h0008, 16'h0000, 16'hFFFF, 5'b00001, 1'b0);
        rd(4'd3, 16'hFFFF);
        issue(8'hD0, 8'h00, 16'h0002, 16'h7FFF, 16'h7FFF, cur_flags, 1'b0);
        issue(8'h50, 8'h10, 16'h0002, 16'h0001, 16'h8000, 5'b00010, 1'b0);
        issue(8'hD0, 8'h00, 16'h0040, 16'hFFFF, 16'hFFFF, cur_flags, 1'b0);
        issue(8'h50, 8'h60, 16'h0040, 16'h0001, 16'h0000, 5'b00001, 1'b0);
        issue(8'hD0, 8'h00, 16'h0080, 16'h8000, 16'h8000, cur_flags, 1'b0);
        issue(8'h90, 8'h70, 16'h0080, 16'h0001, 16'h7FFF, 5'b00010, 1'b0);

        // Compare: flags only, no write, wb_data holds.
        issue(8'hD0, 8'h00, 16'h0010, 16'hFFFF, 16'hFFFF, cur_flags, 1'b0);
        issue(8'hD0, 8'h00, 16'h0020, 16'h0001, 16'h0001, cur_flags, 1'b0);
        issue(8'h0B, 8'h45, 16'h0000, 16'h0000, 16'hFFFE, 5'b10000, 1'b0);
        rd(4'd4, 16'hFFFF);
        issue(8'hB0, 8'h40, 16'h0000, 16'hFFFF, 16'h0000, 5'b01000, 1'b0);
        issue(8'hB0, 8'h50, 16'h0000, 16'h0002, 16'hFFFF, 5'b10101, 1'b0);

        // Logic ops and LUI leave flags alone.
        issue(8'h01, 8'h45, 16'h0100, 16'h0000, 16'h0001, cur_flags, 1'b0);
        issue(8'h20, 8'h50, 16'h0200, 16'h00F0, 16'h00F1, cur_flags, 1'b0);
        issue(8'h30, 8'h40, 16'h0400, 16'h0F0F, 16'hF0F0, cur_flags, 1'b0);
        issue(8'hF0, 8'h00, 16'h0800, 16'h12AB, 16'hAB00, cur_flags, 1'b0);
        issue(8'h03, 8'h44, 16'h1000, 16'h0000, 16'h0000, cur_flags, 1'b0);
        issue(8'h02, 8'h45, 16'h2000, 16'h0000, 16'hFFFF, cur_flags, 1'b0);

        // Multi-hot write, then unsupported words.
        issue(8'hD0, 8'h00, 16'h0006, 16'h1234, 16'h1234, cur_flags, 1'b0);
        rd(4'd1, 16'h1234);
        rd(4'd2, 16'h1234);
        issue(8'h70, 8'h00, 16'h0001, 16'h5555, 16'h0000, cur_flags, 1'b1);
        rd(4'd0, 16'h0000);
        issue(8'h0F, 8'h12, 16'h0001, 16'h0000, 16'h0000, cur_flags, 1'b1);
        issue(8'hxx, 8'h12, 16'h0001, 16'h0000, 16'h0000, cur_flags, 1'b1);
        issue(8'h70, 8'h12, 16'h0000, 16'h0000, 16'h0000, cur_flags, 1'b1);
        rd(4'd0, 16'h0000);

        // Shifter, or illegal when not built.
        issue(8'hD0, 8'h00, 16'h0002, 16'h00F0, 16'h00F0, cur_flags, 1'b0);
        issue(8'hD0, 8'h00, 16'h0004, 16'h0010, 16'h0010, cur_flags, 1'b0);
`ifdef CR16_DATAPATH_SHIFT_EN
        issue(8'h80, 8'h10, 16'h0008, 16'h0004, 16'h0F00, cur_flags, 1'b0);
        issue(8'h80, 8'h10, 16'h0008, 16'h001C, 16'h000F, cur_flags, 1'b0);
        rd(4'd3, 16'h000F);
        issue(8'h84, 8'h12, 16'h0008, 16'h0000, 16'h0000, cur_flags, 1'b0);
        rd(4'd3, 16'h0000);
`else
        issue(8'h80, 8'h10, 16'h0008, 16'h0004, 16'h0000, cur_flags, 1'b1);
        issue(8'h80, 8'h10, 16'h0008, 16'h001C, 16'h0000, cur_flags, 1'b1);
        issue(8'h84, 8'h12, 16'h0008, 16'h0000, 16'h0000, cur_flags, 1'b1);
        rd(4'd3, 16'hFFFF);
`endif
        nop();
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
